alu_op_dispatch: RTL and testbench

- Front end of the execute stage; the opposite end of the ALU result-select path.
- Accepts one ALU request per handshake (opcode, operands A/B, shift amount) and decodes the opcode into a one-hot unit-issue strobe.
- Issues registered operands to the arithmetic, bitwise, shift or mult/div unit, so the downstream result mux only ever sees the unit that was issued.
- Stalls the upstream source while the multi-cycle mult/div unit is busy, and flags illegal opcodes and mult/div timeouts.

---
 rtl/alu_op_dispatch.sv | 166 ++++++++++++++++
 tb/tb_alu_op_dispatch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_dispatch
//  Description : Execute-stage front end. Accepts one ALU request per
//                handshake, decodes the opcode into a one-hot unit-issue
//                strobe, registers the operands for the issued unit, and
//                stalls upstream while the multi-cycle mult/div unit works.
//                Flags illegal opcodes and mult/div timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_dispatch #(
  parameter int WIDTH      = 32,
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [4:0]       in_shamt,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [4:0]       op_shamt,
  output logic             op_sel,
  output logic             issue_arith,
  output logic             issue_logic,
  output logic             issue_shift,
  output logic             issue_md,
  input  logic             md_done,
  output logic             md_busy,
  output logic             err_illegal,
  output logic             err_timeout
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_MD_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [4:0]         op_shamt_q, op_shamt_d;
  logic               op_sel_q, op_sel_d;
  logic               issue_arith_q, issue_arith_d;
  logic               issue_logic_q, issue_logic_d;
  logic               issue_shift_q, issue_shift_d;
  logic               issue_md_q, issue_md_d;
  logic               err_illegal_q, err_illegal_d;
  logic               err_timeout_q, err_timeout_d;
  logic               accept;

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid && in_ready;

  // Next-state decode: accept/issue in IDLE, wait for md_done or timeout in MD_WAIT.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_shamt_d    = op_shamt_q;
    op_sel_d      = op_sel_q;
    issue_arith_d = 1'b0;
    issue_logic_d = 1'b0;
    issue_shift_d = 1'b0;
    issue_md_d    = 1'b0;
    err_illegal_d = 1'b0;
    err_timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Operands are captured even for illegal opcodes.
          op_a_d     = in_a;
          op_b_d     = in_b;
          op_shamt_d = in_shamt;
          op_sel_d   = in_opcode[0];
          if (in_opcode[4:3] != 2'b00) begin
            err_illegal_d = 1'b1;
          end else begin
            case (in_opcode[2:1])
              2'b00:   issue_arith_d = 1'b1;
              2'b01:   issue_logic_d = 1'b1;
              2'b10:   issue_shift_d = 1'b1;
              default: begin
                issue_md_d = 1'b1;
                state_d    = S_MD_WAIT;
                cnt_d      = '0;
              end
            endcase
          end
        end
      end
      S_MD_WAIT: begin
        // Saturating increment so the counter can never wrap back into range.
        cnt_d = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // md_done is ignored during the issue cycle; completion beats timeout.
        if (md_done && !issue_md_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == C_CNT_LAST) begin
          state_d       = S_IDLE;
          cnt_d         = '0;
          err_timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, operand and strobe registers; async reset clears everything at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_shamt_q    <= '0;
      op_sel_q      <= 1'b0;
      issue_arith_q <= 1'b0;
      issue_logic_q <= 1'b0;
      issue_shift_q <= 1'b0;
      issue_md_q    <= 1'b0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_shamt_q    <= op_shamt_d;
      op_sel_q      <= op_sel_d;
      issue_arith_q <= issue_arith_d;
      issue_logic_q <= issue_logic_d;
      issue_shift_q <= issue_shift_d;
      issue_md_q    <= issue_md_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_shamt    = op_shamt_q;
  assign op_sel      = op_sel_q;
  assign issue_arith = issue_arith_q;
  assign issue_logic = issue_logic_q;
  assign issue_shift = issue_shift_q;
  assign issue_md    = issue_md_q;
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;
  assign md_busy     = (state_q == S_MD_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_alu_op_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_dispatch
//  Description : Scoreboard bench for alu_op_dispatch. The driver predicts
//                each strobe (kind, operands, cycle) from the opcode rules;
//                a separate monitor pops and compares whenever a strobe shows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_dispatch;

  localparam int WIDTH      = 32;
  localparam int MD_TIMEOUT = 12;
  localparam int CNT_W      = 4;

  // Strobe kinds, as bit positions in the monitor's strobe vector.
  localparam int K_ARITH = 0, K_LOGIC = 1, K_SHIFT = 2, K_MD = 3, K_ILL = 4, K_TMO = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [4:0]       in_opcode = '0;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [4:0]       in_shamt = '0;
  logic [WIDTH-1:0] op_a, op_b;
  logic [4:0]       op_shamt;
  logic             op_sel;
  logic             issue_arith, issue_logic, issue_shift, issue_md;
  logic             md_done = 1'b0;
  logic             md_busy;
  logic             err_illegal, err_timeout;

  alu_op_dispatch #(.WIDTH(WIDTH), .MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_a(in_a), .in_b(in_b), .in_shamt(in_shamt),
    .op_a(op_a), .op_b(op_b), .op_shamt(op_shamt), .op_sel(op_sel),
    .issue_arith(issue_arith), .issue_logic(issue_logic),
    .issue_shift(issue_shift), .issue_md(issue_md),
    .md_done(md_done), .md_busy(md_busy),
    .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    int               kind;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       sh;
    logic             sel;
    int               cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int kind_of(input logic [4:0] op);
    if (op[4:3] != 2'b00) return K_ILL;
    return int'(op[2:1]);
  endfunction

  // Drive one request that the model knows will be accepted at the next edge.
  task automatic send(input logic [4:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [4:0] sh);
    exp_t e;
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b; in_shamt = sh;
    e.kind = kind_of(op); e.a = a; e.b = b; e.sh = sh; e.sel = op[0]; e.cyc = cyc + 1;
    q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  // Called in the issue_md cycle. n==0: never complete (expect timeout);
  // otherwise md_done is raised so the unit returns to idle n cycles after issue.
  task automatic md_wait(input int n, input bit hold);
    int   waits;
    exp_t e;
    waits = (n == 0) ? MD_TIMEOUT : n;
    if (hold) begin
      in_valid = 1'b1; in_opcode = 5'b00000;
      in_a = $urandom; in_b = $urandom; in_shamt = 5'($urandom_range(0, 31));
    end
    if (n == 0) begin
      e.kind = K_TMO; e.a = '0; e.b = '0; e.sh = '0; e.sel = 1'b0;
      e.cyc = cyc + MD_TIMEOUT;
      q.push_back(e);
    end
    for (int i = 0; i < waits; i++) begin
      chk("md_busy_wait", 64'(md_busy), 64'd1);
      chk("in_ready_stall", 64'(in_ready), 64'd0);
      if (n != 0 && i == waits - 1) md_done = 1'b1;
      tick();
    end
    md_done = 1'b0;
    chk("md_busy_clear", 64'(md_busy), 64'd0);
    chk("in_ready_back", 64'(in_ready), 64'd1);
    if (hold) begin
      e.kind = K_ARITH; e.a = in_a; e.b = in_b; e.sh = in_shamt; e.sel = 1'b0;
      e.cyc = cyc + 1;
      q.push_back(e);
      tick();
      in_valid = 1'b0;
    end
  endtask

  // Monitor: any strobe must match the oldest prediction in kind, cycle and operands.
  always @(negedge clock) begin
    logic [5:0] v;
    exp_t       e;
    if (!reset) begin
      v = {err_timeout, err_illegal, issue_md, issue_shift, issue_logic, issue_arith};
      if (v != 6'b0) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe", 64'(v), 64'd0);
        end else begin
          e = q.pop_front();
          chk("strobe_kind", 64'(v), 64'(6'b1 << e.kind));
          chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
          if (e.kind != K_TMO) begin
            chk("op_a", 64'(op_a), 64'(e.a));
            chk("op_b", 64'(op_b), 64'(e.b));
            chk("op_shamt", 64'(op_shamt), 64'(e.sh));
            chk("op_sel", 64'(op_sel), 64'(e.sel));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, wanted finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] op;
    // Reset state.
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_strobes", 64'({err_timeout, err_illegal, issue_md, issue_shift, issue_logic, issue_arith}), 64'd0);
    chk("rst_md_busy", 64'(md_busy), 64'd0);
    chk("rst_op_a", 64'(op_a), 64'd0);
    reset = 1'b0;
    tick();

    // Back-to-back single-cycle ops.
    send(5'b00000, 32'd7, 32'd3, 5'd2);
    chk("b2b_ready0", 64'(in_ready), 64'd1);
    send(5'b00011, 32'd7, 32'd3, 5'd2);
    chk("b2b_ready1", 64'(in_ready), 64'd1);
    send(5'b00101, 32'd7, 32'd3, 5'd2);
    chk("b2b_ready2", 64'(in_ready), 64'd1);

    // Mult/div with a held request stalled behind it.
    send(5'b00110, 32'd6, 32'd7, 5'd0);
    md_wait(5, 1'b1);

    // Timeout, then md_done coinciding with the timeout edge.
    send(5'b00111, 32'd9, 32'd4, 5'd1);
    md_wait(0, 1'b0);
    send(5'b00110, 32'd1, 32'd2, 5'd3);
    md_wait(MD_TIMEOUT, 1'b0);

    // Illegal opcode still captures operands.
    send(5'b01000, 32'h5555_aaaa, 32'h1234, 5'd9);
    tick();

    // Reset in the middle of MD_WAIT.
    send(5'b00110, 32'd11, 32'd12, 5'd4);
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("midrst_md_busy", 64'(md_busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_op_a", 64'(op_a), 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // md_done while idle has no effect.
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    tick();
    chk("idle_done_ready", 64'(in_ready), 64'd1);
    chk("idle_done_busy", 64'(md_busy), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      op = 5'($urandom_range(0, 31));
      send(op, $urandom, $urandom, 5'($urandom_range(0, 31)));
      if (kind_of(op) == K_MD) begin
        if ($urandom_range(0, 3) == 0) md_wait(0, 1'($urandom_range(0, 1)));
        else md_wait($urandom_range(2, MD_TIMEOUT), 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 3) == 0) begin
        tick();
      end
    end

    tick(); tick(); tick();
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
